clock_set_ctrl: RTL and testbench

Time-setting controller for the FPGA clock. It turns two raw push-buttons (mode, increment) into a setting sequence for the seconds, minutes and hours BCD counters. While a setting state is active it freezes all three counters through their load inputs and drives BCD edit values onto the load buses. It sits between the board buttons and the display/counter datapath, runs on the 50 MHz board clock, and leaves the divided 1 Hz timebase untouched.

---
 rtl/clock_pkg.sv | 53 +++++
 rtl/btn_debounce.sv | 48 ++++
 rtl/clock_set_ctrl.sv | 154 +++++++++++++++
 tb/tb_clock_set_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared encodings and BCD helpers for the clock time-setting controller.
// Time fields are packed BCD digit pairs {tens, ones}.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SET_H = 2'd1,
    ST_SET_M = 2'd2,
    ST_SET_S = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX           = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX      = 4'd5;
  localparam logic [3:0] MIN_TENS_MAX      = 4'd5;
  localparam logic [3:0] HR_TENS_MAX       = 4'd2;
  localparam logic [3:0] HR_ONES_AT_TOP    = 4'd3;

  typedef struct packed {
    logic [3:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
    logic [3:0] s1;
    logic [3:0] s0;
  } bcd_time_t;

  // Minutes/seconds style field: valid range 00..{tens_max}9.
  function automatic logic sexa_valid(input logic [3:0] tens, input logic [3:0] ones,
                                      input logic [3:0] tens_max);
    return (ones <= BCD_MAX) && (tens <= tens_max);
  endfunction

  function automatic logic hours_valid(input logic [3:0] tens, input logic [3:0] ones);
    return (ones <= BCD_MAX) &&
           ((tens < HR_TENS_MAX) || ((tens == HR_TENS_MAX) && (ones <= HR_ONES_AT_TOP)));
  endfunction

  function automatic logic [7:0] sexa_inc(input logic [3:0] tens, input logic [3:0] ones,
                                          input logic [3:0] tens_max);
    if (ones >= BCD_MAX) begin
      if (tens >= tens_max) return 8'h00;
      return {tens + 4'd1, 4'd0};
    end
    return {tens, ones + 4'd1};
  endfunction

  function automatic logic [7:0] hours_inc(input logic [3:0] tens, input logic [3:0] ones);
    if ((tens >= HR_TENS_MAX) && (ones >= HR_ONES_AT_TOP)) return 8'h00;
    if (ones >= BCD_MAX) return {tens + 4'd1, 4'd0};
    return {tens, ones + 4'd1};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus counting debouncer for one raw push-button.
// press is a registered single-cycle pulse on each debounced 0->1 change.
module btn_debounce #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic CLOCK,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      sync_1  <= 1'b0;
      sync_2  <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_1  <= raw;
      sync_2  <= sync_1;
      level_d <= level;
      press   <= level & ~level_d;
      // Any sample that agrees with the accepted level restarts the count.
      if (sync_2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync_2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: RUN -> SET_H -> SET_M -> SET_S -> RUN on mode presses,
// BCD edit registers driven onto the counter load buses while setting.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int DEB_CYCLES     = 50000,
  parameter int BLINK_CYCLES   = 12500000,
  parameter int TIMEOUT_CYCLES = 500000000
) (
  input  logic       CLOCK,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [3:0] S0,
  input  logic [3:0] S1,
  input  logic [3:0] M0,
  input  logic [3:0] M1,
  input  logic [3:0] H0,
  input  logic [3:0] H1,
  output logic       set_s,
  output logic       set_m,
  output logic       set_h,
  output logic [3:0] S0_ld,
  output logic [3:0] S1_ld,
  output logic [3:0] M0_ld,
  output logic [3:0] M1_ld,
  output logic [3:0] H0_ld,
  output logic [3:0] H1_ld,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int IW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [IW-1:0] IDLE_LAST  = IW'(TIMEOUT_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  logic          mode_level;
  logic          inc_level;
  logic          mode_p;
  logic          inc_p;
  logic          unused_levels;
  state_t        state;
  state_t        state_next;
  logic          set_q;
  bcd_time_t     edit;
  logic [IW-1:0] idle_cnt;
  logic [BW-1:0] blink_cnt;
  logic          blink_q;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .CLOCK (CLOCK),
    .rst   (rst),
    .raw   (btn_mode),
    .level (mode_level),
    .press (mode_p)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
    .CLOCK (CLOCK),
    .rst   (rst),
    .raw   (btn_inc),
    .level (inc_level),
    .press (inc_p)
  );

  assign unused_levels = mode_level | inc_level;

  // State register; set_q is registered alongside so loads switch on the mode edge.
  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
      set_q <= 1'b0;
    end else begin
      state <= state_next;
      set_q <= (state_next != ST_RUN);
    end
  end

  always_comb begin
    state_next = state;
    if (mode_p) begin
      case (state)
        ST_RUN:   state_next = ST_SET_H;
        ST_SET_H: state_next = ST_SET_M;
        ST_SET_M: state_next = ST_SET_S;
        default:  state_next = ST_RUN;
      endcase
    end else if ((state != ST_RUN) && (idle_cnt == IDLE_LAST)) begin
      state_next = ST_RUN;
    end
  end

  always_comb begin
    mode  = state;
    set_s = set_q;
    set_m = set_q;
    set_h = set_q;
    blink = blink_q & (state != ST_RUN);
    H1_ld = edit.h1;
    H0_ld = edit.h0;
    M1_ld = edit.m1;
    M0_ld = edit.m0;
    S1_ld = edit.s1;
    S0_ld = edit.s0;
  end

  // Mode takes priority: an inc pulse in the same cycle as a mode pulse is dropped.
  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      edit <= '0;
    end else if (mode_p) begin
      if (state == ST_RUN) begin
        {edit.h1, edit.h0} <= hours_valid(H1, H0) ? {H1, H0} : 8'h00;
        {edit.m1, edit.m0} <= sexa_valid(M1, M0, MIN_TENS_MAX) ? {M1, M0} : 8'h00;
        {edit.s1, edit.s0} <= sexa_valid(S1, S0, SEC_TENS_MAX) ? {S1, S0} : 8'h00;
      end
    end else if (inc_p) begin
      case (state)
        ST_SET_H: {edit.h1, edit.h0} <= hours_inc(edit.h1, edit.h0);
        ST_SET_M: {edit.m1, edit.m0} <= sexa_inc(edit.m1, edit.m0, MIN_TENS_MAX);
        ST_SET_S: {edit.s1, edit.s0} <= sexa_inc(edit.s1, edit.s0, SEC_TENS_MAX);
        default:  ;
      endcase
    end
  end

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (mode_p || inc_p || (state_next != state) || (state == ST_RUN)) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // Blink phase restarts high on every state entry so the new field shows at once.
  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      blink_q   <= 1'b0;
      blink_cnt <= '0;
    end else if (state_next != state) begin
      blink_q   <= 1'b1;
      blink_cnt <= '0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_q   <= ~blink_q;
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed and randomized bench for clock_set_ctrl against an integer-time model
// (hours/minutes/seconds as plain numbers, state as a 0..3 index).
module tb_clock_set_ctrl;

  localparam int DEB = 4;
  localparam int BLK = 8;
  localparam int TO  = 200;

  logic       CLOCK = 1'b0;
  logic       rst;
  logic       btn_mode;
  logic       btn_inc;
  logic [3:0] S0, S1, M0, M1, H0, H1;
  logic       set_s, set_m, set_h;
  logic [3:0] S0_ld, S1_ld, M0_ld, M1_ld, H0_ld, H1_ld;
  logic [1:0] mode;
  logic       blink;

  clock_set_ctrl #(
    .DEB_CYCLES     (DEB),
    .BLINK_CYCLES   (BLK),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLOCK    (CLOCK),
    .rst      (rst),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .S0       (S0),
    .S1       (S1),
    .M0       (M0),
    .M1       (M1),
    .H0       (H0),
    .H1       (H1),
    .set_s    (set_s),
    .set_m    (set_m),
    .set_h    (set_h),
    .S0_ld    (S0_ld),
    .S1_ld    (S1_ld),
    .M0_ld    (M0_ld),
    .M1_ld    (M1_ld),
    .H0_ld    (H0_ld),
    .H1_ld    (H1_ld),
    .mode     (mode),
    .blink    (blink)
  );

  // clock / reset block
  always #5 CLOCK = ~CLOCK;

  int cyc = 0;
  always @(posedge CLOCK) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d expected_finish_before=%0d", cyc, 100000);
    $fatal(1, "watchdog expired");
  end

  // reference model state
  int checks = 0;
  int errors = 0;
  int st, eh, em, es;
  int act_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/mode"},  32'(mode),  32'(st));
    check({tag, "/set_h"}, 32'(set_h), 32'(st != 0));
    check({tag, "/set_m"}, 32'(set_m), 32'(st != 0));
    check({tag, "/set_s"}, 32'(set_s), 32'(st != 0));
    check({tag, "/H1_ld"}, 32'(H1_ld), 32'(eh / 10));
    check({tag, "/H0_ld"}, 32'(H0_ld), 32'(eh % 10));
    check({tag, "/M1_ld"}, 32'(M1_ld), 32'(em / 10));
    check({tag, "/M0_ld"}, 32'(M0_ld), 32'(em % 10));
    check({tag, "/S1_ld"}, 32'(S1_ld), 32'(es / 10));
    check({tag, "/S0_ld"}, 32'(S0_ld), 32'(es % 10));
  endtask

  function automatic int field_val(input int tens, input int ones, input int limit);
    int v;
    if (tens > 9 || ones > 9) return 0;
    v = tens * 10 + ones;
    return (v > limit) ? 0 : v;
  endfunction

  task automatic model_press(input bit m, input bit i);
    if (m) begin
      if (st == 0) begin
        eh = field_val(int'(H1), int'(H0), 23);
        em = field_val(int'(M1), int'(M0), 59);
        es = field_val(int'(S1), int'(S0), 59);
      end
      st = (st + 1) % 4;
    end else if (i) begin
      case (st)
        1: eh = (eh + 1) % 24;
        2: em = (em + 1) % 60;
        3: es = (es + 1) % 60;
        default: ;
      endcase
    end
  endtask

  // driver tasks
  task automatic set_time(input int h1, input int h0, input int m1, input int m0,
                          input int s1, input int s0);
    H1 = 4'(h1); H0 = 4'(h0); M1 = 4'(m1); M0 = 4'(m0); S1 = 4'(s1); S0 = 4'(s0);
  endtask

  // Clean press: action lands exactly DEB+4 edges after the first high sample.
  task automatic press(input string tag, input bit m, input bit i);
    @(negedge CLOCK);
    btn_mode = m;
    btn_inc  = i;
    repeat (DEB + 3) @(posedge CLOCK);
    #1 check_all({tag, "/pre"});
    @(posedge CLOCK);
    #1;
    model_press(m, i);
    act_cyc = cyc;
    check_all({tag, "/act"});
    if (m) begin
      check({tag, "/blink0"}, 32'(blink), 32'(st != 0));
      repeat (BLK - 1) @(posedge CLOCK);
      #1 check({tag, "/blink7"}, 32'(blink), 32'(st != 0));
      @(posedge CLOCK);
      #1 check({tag, "/blink8"}, 32'(blink), 32'd0);
    end else begin
      repeat (BLK) @(posedge CLOCK);
      #1 check_all({tag, "/held"});
    end
    @(negedge CLOCK);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (DEB + 6) @(posedge CLOCK);
    #1 check_all({tag, "/rel"});
  endtask

  task automatic bounce_inc();
    repeat (5) begin
      @(negedge CLOCK);
      btn_inc = 1'b1;
      repeat (3) @(negedge CLOCK);
      btn_inc = 1'b0;
      repeat (2) @(negedge CLOCK);
    end
    repeat (DEB + 6) @(posedge CLOCK);
    #1 check_all("bounce");
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    set_time(0, 0, 0, 0, 0, 0);
    st = 0; eh = 0; em = 0; es = 0;
    repeat (3) @(posedge CLOCK);
    #1 check_all("reset");
    check("reset/blink", 32'(blink), 32'd0);
    @(negedge CLOCK);
    rst = 1'b0;

    // snapshot of 12:34:56, then edits with the counter inputs moving underneath
    set_time(1, 2, 3, 4, 5, 6);
    press("snap", 1'b1, 1'b0);
    set_time(0, 7, 0, 8, 0, 9);
    press("inc_h", 1'b0, 1'b1);
    press("to_m", 1'b1, 1'b0);
    press("inc_m", 1'b0, 1'b1);
    press("to_s", 1'b1, 1'b0);
    press("inc_s", 1'b0, 1'b1);
    press("commit", 1'b1, 1'b0);
    press("run_inc", 1'b0, 1'b1);

    // hours wrap, minutes carry 09->10, seconds 58->59->00
    set_time(2, 3, 0, 9, 5, 8);
    press("snap2", 1'b1, 1'b0);
    press("h_wrap", 1'b0, 1'b1);
    press("to_m2", 1'b1, 1'b0);
    press("m_carry", 1'b0, 1'b1);
    press("to_s2", 1'b1, 1'b0);
    press("s_59", 1'b0, 1'b1);
    press("s_wrap", 1'b0, 1'b1);
    press("commit2", 1'b1, 1'b0);

    // minutes wrap, bounce rejection, simultaneous mode+inc
    set_time(1, 9, 5, 9, 3, 0);
    press("snap3", 1'b1, 1'b0);
    press("to_m3", 1'b1, 1'b0);
    press("m_wrap", 1'b0, 1'b1);
    bounce_inc();
    press("simul", 1'b1, 1'b1);
    press("commit3", 1'b1, 1'b0);

    // invalid snapshot digits are sanitized per field
    set_time(2, 7, 4, 5, 1, 12);
    press("snap_bad", 1'b1, 1'b0);
    press("bad_m", 1'b1, 1'b0);
    press("bad_s", 1'b1, 1'b0);
    press("bad_run", 1'b1, 1'b0);

    // randomized rounds
    for (int r = 0; r < 4; r++) begin
      set_time($urandom_range(0, 3), $urandom_range(0, 11), $urandom_range(0, 6),
               $urandom_range(0, 11), $urandom_range(0, 6), $urandom_range(0, 11));
      press("rnd_snap", 1'b1, 1'b0);
      for (int f = 0; f < 3; f++) begin
        int n;
        n = $urandom_range(0, 2);
        for (int k = 0; k < n; k++) press("rnd_inc", 1'b0, 1'b1);
        press("rnd_mode", 1'b1, 1'($urandom_range(0, 1)));
      end
    end

    // idle timeout in SET_M
    set_time(0, 5, 1, 0, 2, 0);
    press("to_snap", 1'b1, 1'b0);
    press("to_setm", 1'b1, 1'b0);
    guard = 0;
    while ((cyc != act_cyc + TO - 1) && (guard < TO + 10)) begin
      @(posedge CLOCK);
      #1;
      guard++;
    end
    check_all("timeout_pre");
    @(posedge CLOCK);
    #1;
    st = 0;
    check_all("timeout");
    check("timeout/blink", 32'(blink), 32'd0);

    // asynchronous reset in the middle of SET_H
    set_time(0, 8, 1, 5, 4, 2);
    press("rst_snap", 1'b1, 1'b0);
    @(negedge CLOCK);
    #2 rst = 1'b1;
    st = 0; eh = 0; em = 0; es = 0;
    #1 check_all("rst_async");
    check("rst_async/blink", 32'(blink), 32'd0);
    @(negedge CLOCK);
    rst = 1'b0;
    repeat (3) @(posedge CLOCK);
    #1 check_all("rst_after");

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
